// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline's memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_whbs;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_whbs,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_whbs,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with byte/half/word lane steering
// and a programmable number of wait states before each access commits.
//
// state | meaning
// IDLE  | ready for a request; accepts on req_valid
// WAIT  | counting down wait states for the captured request
// RESP  | one-cycle response strobe; returns to IDLE
module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic             CLK,
   input  logic             rst,
   dmem_responder_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int         DEPTH   = 1 << ADDR_W;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [1:0]          whbs_q;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                cap_en;
   logic                commit;

   logic [31:0]         mem_q [DEPTH];

   logic                a_we;
   logic [ADDR_W+1:0]   a_addr;
   logic [31:0]         a_wdata;
   logic [1:0]          a_whbs;
   logic [ADDR_W-1:0]   a_idx;
   logic                a_mis;
   logic [3:0]          a_be;
   logic [31:0]         a_wword;
   logic [31:0]         rd_word;
   logic [31:0]         ld_data;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic                unused_addr;

   assign unused_addr = ^bus.req_addr[31:ADDR_W+2];

   // With zero wait states the access commits on the acceptance edge, so the
   // live request fields are used instead of the (not yet loaded) captures.
   always_comb begin
      if (state_q == IDLE) begin
         a_we    = bus.req_we;
         a_addr  = bus.req_addr[ADDR_W+1:0];
         a_wdata = bus.req_wdata;
         a_whbs  = bus.req_whbs;
      end else begin
         a_we    = we_q;
         a_addr  = addr_q;
         a_wdata = wdata_q;
         a_whbs  = whbs_q;
      end
   end

   assign a_idx   = a_addr[ADDR_W+1:2];
   assign rd_word = mem_q[a_idx];

   always_comb begin
      a_mis   = 1'b0;
      a_be    = 4'b0000;
      a_wword = a_wdata;
      ld_byte = rd_word[7:0];
      ld_half = a_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (a_addr[1:0])
         2'd0:    ld_byte = rd_word[7:0];
         2'd1:    ld_byte = rd_word[15:8];
         2'd2:    ld_byte = rd_word[23:16];
         default: ld_byte = rd_word[31:24];
      endcase
      case (a_whbs)
         2'b00: begin
            a_be            = 4'b0001 << a_addr[1:0];
            a_wword         = {4{a_wdata[7:0]}};
            ld_data         = {24'b0, ld_byte};
         end
         2'b01: begin
            a_mis           = a_addr[0];
            a_be            = a_addr[1] ? 4'b1100 : 4'b0011;
            a_wword         = {2{a_wdata[15:0]}};
            ld_data         = {16'b0, ld_half};
         end
         default: begin
            a_mis           = (a_addr[1:0] != 2'b00);
            a_be            = 4'b1111;
            ld_data         = rd_word;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_en  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               cap_en = 1'b1;
               cnt_d  = WAIT_LD;
               if (WAIT_LD == 4'd0) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
               commit  = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (commit) begin
         err_d   = a_mis;
         rdata_d = (a_we || a_mis) ? 32'b0 : ld_data;
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'b0;
         whbs_q  <= 2'b00;
         rdata_q <= 32'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (cap_en) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr[ADDR_W+1:0];
            wdata_q <= bus.req_wdata;
            whbs_q  <= bus.req_whbs;
         end
      end
   end

   // Storage is deliberately unreset; rst gating keeps an abandoned store out.
   always_ff @(posedge CLK) begin
      if (commit && a_we && !a_mis && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (a_be[b]) mem_q[a_idx][8*b +: 8] <= a_wword[8*b +: 8];
         end
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one zero-wait instance and one
// three-wait-state instance, driven through their bus interfaces.
module tb_dmem_responder;

   logic clk;
   logic rst0, rst3;
   int   total, bad;

   dmem_responder_if if0 ();
   dmem_responder_if if3 ();

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.CLK(clk), .rst(rst0), .bus(if0));
   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (.CLK(clk), .rst(rst3), .bus(if3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic drive(input bit sel, input bit v, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] whbs);
      if (sel) begin
         if3.req_valid = v; if3.req_we = we; if3.req_addr = addr;
         if3.req_wdata = wdata; if3.req_whbs = whbs;
      end else begin
         if0.req_valid = v; if0.req_we = we; if0.req_addr = addr;
         if0.req_wdata = wdata; if0.req_whbs = whbs;
      end
   endtask

   // Issue one request and wait (bounded) for its response; lat = 99 on timeout.
   task automatic do_req(input bit sel, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] whbs,
                         output logic [31:0] rdata, output logic err, output int lat);
      bit acc, rdy, got;
      acc = 0; got = 0; lat = 99; rdata = 32'hxxxxxxxx; err = 1'bx;
      @(negedge clk);
      drive(sel, 1'b1, we, addr, wdata, whbs);
      for (int i = 0; i < 40 && !acc; i++) begin
         rdy = sel ? if3.req_ready : if0.req_ready;
         @(posedge clk);
         if (rdy) acc = 1;
      end
      #1;
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      if (acc) begin
         for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (sel ? if3.rsp_valid : if0.rsp_valid) begin
               got = 1; lat = k;
               rdata = sel ? if3.rsp_rdata : if0.rsp_rdata;
               err   = sel ? if3.rsp_err   : if0.rsp_err;
            end
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (if0.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready0 got=%b exp=1", if0.req_ready); end
      total++; if (if0.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid0 got=%b exp=0", if0.rsp_valid); end
      total++; if (if0.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata0 got=%h exp=0", if0.rsp_rdata); end
      total++; if (if0.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err0 got=%b exp=0", if0.rsp_err); end
      total++; if (if3.req_ready !== 1'b1 || if3.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_dut3 ready=%b valid=%b exp ready=1 valid=0", if3.req_ready, if3.rsp_valid);
      end
   endtask

   task automatic test_word();
      logic [31:0] rd; logic er; int lat;
      do_req(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, rd, er, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL word_store_lat got=%0d exp=1", lat); end
      total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL word_store_rsp rdata=%h err=%b exp 0/0", rd, er); end
      do_req(0, 0, 32'h10, 32'h0, 2'b10, rd, er, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL word_load_lat got=%0d exp=1", lat); end
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_load got=%h exp=deadbeef", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL word_load_err got=%b exp=0", er); end
      @(negedge clk);
      total++; if (if0.rsp_valid !== 1'b0 || if0.rsp_rdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL rsp_hold valid=%b rdata=%h exp 0/deadbeef", if0.rsp_valid, if0.rsp_rdata);
      end
   endtask

   task automatic test_lanes();
      logic [31:0] rd; logic er; int lat;
      do_req(0, 1, 32'h12, 32'hFFFFFF55, 2'b00, rd, er, lat);
      total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL byte_store_rsp rdata=%h err=%b exp 0/0", rd, er); end
      do_req(0, 0, 32'h10, 32'h0, 2'b11, rd, er, lat);
      total++; if (rd !== 32'hDE55BEEF) begin bad++; $display("FAIL lane_word got=%h exp=de55beef", rd); end
      do_req(0, 0, 32'h13, 32'h0, 2'b00, rd, er, lat);
      total++; if (rd !== 32'h000000DE || er !== 1'b0) begin bad++; $display("FAIL byte_load13 got=%h err=%b exp=000000de", rd, er); end
      do_req(0, 0, 32'h10, 32'h0, 2'b00, rd, er, lat);
      total++; if (rd !== 32'h000000EF) begin bad++; $display("FAIL byte_load10 got=%h exp=000000ef", rd); end
      do_req(0, 0, 32'h12, 32'h0, 2'b01, rd, er, lat);
      total++; if (rd !== 32'h0000DE55 || er !== 1'b0) begin bad++; $display("FAIL half_load12 got=%h err=%b exp=0000de55", rd, er); end
      do_req(0, 0, 32'h10, 32'h0, 2'b01, rd, er, lat);
      total++; if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL half_load10 got=%h exp=0000beef", rd); end
   endtask

   task automatic test_misalign();
      logic [31:0] rd; logic er; int lat;
      do_req(0, 1, 32'h20, 32'h11223344, 2'b10, rd, er, lat);
      do_req(0, 1, 32'h21, 32'h00001234, 2'b01, rd, er, lat);
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL half_store_mis err=%b rdata=%h exp 1/0", er, rd); end
      do_req(0, 0, 32'h20, 32'h0, 2'b10, rd, er, lat);
      total++; if (rd !== 32'h11223344 || er !== 1'b0) begin bad++; $display("FAIL mis_nowrite got=%h err=%b exp=11223344/0", rd, er); end
      do_req(0, 0, 32'h22, 32'h0, 2'b10, rd, er, lat);
      total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL word_load_mis err=%b rdata=%h exp 1/0", er, rd); end
      do_req(0, 0, 32'h21, 32'h0, 2'b00, rd, er, lat);
      total++; if (er !== 1'b0 || rd !== 32'h00000033) begin bad++; $display("FAIL byte_odd err=%b rdata=%h exp 0/00000033", er, rd); end
      do_req(0, 1, 32'h22, 32'h00001234, 2'b01, rd, er, lat);
      do_req(0, 0, 32'h20, 32'h0, 2'b10, rd, er, lat);
      total++; if (rd !== 32'h12343344) begin bad++; $display("FAIL half_store_hi got=%h exp=12343344", rd); end
   endtask

   task automatic test_alias();
      logic [31:0] rd; logic er; int lat;
      do_req(0, 1, 32'h1000, 32'hA5A5A5A5, 2'b10, rd, er, lat);
      do_req(0, 0, 32'h0, 32'h0, 2'b10, rd, er, lat);
      total++; if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL alias_wrap got=%h exp=a5a5a5a5", rd); end
   endtask

   task automatic test_back_to_back();
      logic [9:0] rv, vv;
      logic [31:0] rd; logic er; int lat;
      rv = '0; vv = '0;
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 2'b10);
      for (int s = 0; s < 10; s++) begin
         if (s > 0) @(negedge clk);
         rv[s] = if3.req_ready;
         vv[s] = if3.rsp_valid;
         if (s == 9) drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      end
      total++; if (rv !== 10'b0000100001) begin bad++; $display("FAIL wait3_ready got=%b exp=0000100001", rv); end
      total++; if (vv !== 10'b1000010000) begin bad++; $display("FAIL wait3_valid got=%b exp=1000010000", vv); end
      do_req(1, 0, 32'h40, 32'h0, 2'b10, rd, er, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL wait3_lat got=%0d exp=4", lat); end
      total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL wait3_load got=%h exp=cafef00d", rd); end
   endtask

   task automatic test_reset_wait();
      logic [31:0] rd; logic er; int lat;
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 32'h40, 32'h0BADF00D, 2'b10);
      @(posedge clk);
      #1;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      @(negedge clk);
      total++; if (if3.req_ready !== 1'b0 || if3.rsp_rdata !== 32'hCAFEF00D) begin
         bad++; $display("FAIL pre_reset ready=%b rdata=%h exp 0/cafef00d", if3.req_ready, if3.rsp_rdata);
      end
      rst3 = 1'b1;
      #1;
      total++; if (if3.rsp_valid !== 1'b0 || if3.rsp_rdata !== 32'h0 || if3.rsp_err !== 1'b0) begin
         bad++; $display("FAIL mid_reset valid=%b rdata=%h err=%b exp 0/0/0", if3.rsp_valid, if3.rsp_rdata, if3.rsp_err);
      end
      @(negedge clk);
      rst3 = 1'b0;
      do_req(1, 0, 32'h40, 32'h0, 2'b10, rd, er, lat);
      total++; if (rd !== 32'hCAFEF00D || lat !== 4) begin bad++; $display("FAIL abandoned_store rdata=%h lat=%0d exp cafef00d/4", rd, lat); end
   endtask

   initial begin
      total = 0; bad = 0;
      rst0 = 1'b1; rst3 = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      repeat (3) @(negedge clk);
      rst0 = 1'b0; rst3 = 1'b0;
      test_reset();
      test_word();
      test_lanes();
      test_misalign();
      test_alias();
      test_back_to_back();
      test_reset_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
